eth_tx_sched: RTL
=================

# eth_tx_sched

Transmit scheduler for the Ethernet TX path. It arbitrates between the ARP and UDP frame builders with round-robin priority and generates the 7×0x55 + 0xD5 preamble/SFD. It then steers the granted builder's payload bytes into both the line and the FCS generator, and splices the four FCS bytes onto the line. It finishes each frame by enforcing the inter-frame gap. It sits between the frame builders and the PHY-side byte interface, and it owns the start/done handshakes of the FCS generator.

## Interface
Parameters:
- PREAMBLE_LEN, 7: number of 0x55 bytes before the SFD (0xD5).
- IFG_CYCLES, 12: idle cycles after the last FCS byte before the next arbitration.
- CNT_W, 16: width of the per-source frame counters.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- arp_req  in  1  ARP builder has a frame; level, held until arp_start.
- udp_req  in  1  UDP builder has a frame; level, held until udp_start.
- arp_start  out  1  one-cycle pulse: ARP builder presents its first byte next cycle.
- udp_start  out  1  one-cycle pulse: UDP builder presents its first byte next cycle.
- arp_data  in  8  ARP payload byte; one byte per cycle after arp_start.
- udp_data  in  8  UDP payload byte; one byte per cycle after udp_start.
- arp_data_done  in  1  high with ARP's last byte.
- udp_data_done  in  1  high with UDP's last byte.
- preamble_sfd_tx_done  out  1  to FCS generator; high during the SFD cycle.
- fcs_data  out  8  to FCS generator data_in; granted source byte in PAYLOAD, else 0.
- payload_done  out  1  to FCS generator done input; the granted source's done, gated by PAYLOAD.
- fcs_byte  in  8  FCS generator data_out.
- fcs_tx_done  in  1  FCS generator: high with the 4th FCS byte.
- tx_data  out  8  registered line byte.
- tx_en  out  1  registered line valid.
- busy  out  1  state != IDLE.
- arp_frame_cnt  out  CNT_W  completed ARP frames; wraps.
- udp_frame_cnt  out  CNT_W  completed UDP frames; wraps.

## Operation
- States: IDLE, PREAMBLE, PAYLOAD, FCS, IFG.
- IDLE: if any request is pending, latch the grant and go to PREAMBLE.
  - If both requests are pending, grant the source not served last.
  - last_served resets to UDP, so ARP wins the first tie.
  - A request dropped before its start pulse is ignored.
- PREAMBLE: byte counter 0..PREAMBLE_LEN.
  - Counts 0..PREAMBLE_LEN-1 send 0x55.
  - The final count sends 0xD5, asserts preamble_sfd_tx_done and the granted source's start pulse, then moves to PAYLOAD.
- PAYLOAD: line byte, fcs_data and payload_done follow the granted source combinationally.
  - The non-granted source's data and done are ignored.
  - On the granted done, go to FCS and update last_served.
- FCS: line byte = fcs_byte. On fcs_tx_done:
  - increment the granted source's counter;
  - load the IFG counter and go to IFG.
- IFG: tx_en=0 for IFG_CYCLES cycles, then go to IDLE. Requests are not sampled during IFG.
- Line-byte validity: the line byte is valid in PREAMBLE, PAYLOAD and FCS; it is 0 and invalid in IDLE/IFG. tx_data/tx_en are its registered copy.
- Minimum-length padding and payload content are the builders' responsibility.

## Timing
- Reset (asynchronous, immediate) clears:
  - state to IDLE; last_served to UDP; all counters to 0;
  - tx_data, tx_en, busy, start pulses, preamble_sfd_tx_done, payload_done, fcs_data to 0.
- Reset mid-frame truncates the frame on the line. The FCS generator shares areset.
- Frame timeline with request seen in IDLE at cycle 0 and N payload bytes:
  - PREAMBLE cycles 1..PREAMBLE_LEN+1; SFD plus start pulse at cycle PREAMBLE_LEN+1 (8 by default).
  - PAYLOAD cycles 9..8+N; done at cycle 8+N.
  - FCS cycles 9+N..12+N; fcs_tx_done at 12+N.
  - IFG cycles 13+N..24+N; IDLE at 25+N.
- tx_data/tx_en lag the internal line byte by exactly 1 cycle. First tx_en=1 is at cycle 2.
- N=1 is legal: done may coincide with the first payload cycle.
- A request asserted during IFG waits; it is granted in the first IDLE cycle.
- A counter increments on the fcs_tx_done edge and is visible the next cycle; it wraps 0xFFFF→0.

## Test plan
- Single ARP frame, N=28, udp_req=0. Required:
  - tx_data shows 0x55×7, 0xD5, the 28 bytes, then 4 FCS bytes;
  - tx_en high for 40 consecutive cycles;
  - arp_frame_cnt=1; next IDLE 12 cycles after the last FCS byte.
- arp_req and udp_req both asserted from reset. Required:
  - ARP is granted first, then UDP;
  - with both held continuously, grants alternate ARP, UDP, ARP, UDP;
  - counters end at 2/2 after 4 frames.
- UDP frame with the payload 0x00..0x09 (N=10). Required:
  - the FCS bytes on tx_data equal the reference CRC-32 (~crc, LSB byte first) of those 10 bytes;
  - preamble_sfd_tx_done is high exactly one cycle, coincident with udp_start.
- ARP granted while a spurious udp_data_done pulses mid-payload. Required:
  - payload_done is not asserted by the spurious UDP pulse;
  - the frame length is unchanged; udp_frame_cnt stays 0.
- areset asserted in the middle of PAYLOAD. Required:
  - tx_en=0, busy=0 and the state is IDLE immediately;
  - after release, a new arp_req produces a full, correct frame.
- N=1 frame. Required:
  - PAYLOAD lasts one cycle;
  - FCS follows immediately;
  - total tx_en width is 13 cycles.

Source files
------------

// File: rtl/eth_tx_sched_if.sv
// eth_tx_sched_if: builder, FCS-generator and line-side signals of the TX scheduler
interface eth_tx_sched_if #(
   parameter int CNT_W = 16
);
   logic             arp_req;
   logic             udp_req;
   logic             arp_start;
   logic             udp_start;
   logic [7:0]       arp_data;
   logic [7:0]       udp_data;
   logic             arp_data_done;
   logic             udp_data_done;
   logic             preamble_sfd_tx_done;
   logic [7:0]       fcs_data;
   logic             payload_done;
   logic [7:0]       fcs_byte;
   logic             fcs_tx_done;
   logic [7:0]       tx_data;
   logic             tx_en;
   logic             busy;
   logic [CNT_W-1:0] arp_frame_cnt;
   logic [CNT_W-1:0] udp_frame_cnt;
   modport slave (
      input  arp_req, udp_req, arp_data, udp_data, arp_data_done, udp_data_done, fcs_byte, fcs_tx_done,
      output arp_start, udp_start, preamble_sfd_tx_done, fcs_data, payload_done, tx_data, tx_en, busy,
             arp_frame_cnt, udp_frame_cnt
   );
   modport master (
      output arp_req, udp_req, arp_data, udp_data, arp_data_done, udp_data_done, fcs_byte, fcs_tx_done,
      input  arp_start, udp_start, preamble_sfd_tx_done, fcs_data, payload_done, tx_data, tx_en, busy,
             arp_frame_cnt, udp_frame_cnt
   );
endinterface

// File: rtl/eth_tx_sched.sv
// eth_tx_sched: round-robin ARP/UDP transmit scheduler with preamble/SFD, FCS splice and inter-frame gap
module eth_tx_sched #(
   parameter int PREAMBLE_LEN = 7,
   parameter int IFG_CYCLES   = 12,
   parameter int CNT_W        = 16
) (
   input logic           aclk,
   input logic           areset,
   eth_tx_sched_if.slave bus
);
   localparam int PW = $clog2(PREAMBLE_LEN + 1);
   localparam int IW = $clog2(IFG_CYCLES + 1);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PRE  = 3'd1;
   localparam logic [2:0] S_PAY  = 3'd2;
   localparam logic [2:0] S_FCS  = 3'd3;
   localparam logic [2:0] S_IFG  = 3'd4;
   logic [2:0]       state;
   logic [PW-1:0]    pre_cnt;
   logic [IW-1:0]    ifg_cnt;
   logic             gnt_udp;
   logic             last_udp;
   logic [CNT_W-1:0] arp_cnt;
   logic [CNT_W-1:0] udp_cnt;
   logic             in_pre;
   logic             in_pay;
   logic             in_fcs;
   logic             sfd;
   logic             src_done;
   logic [7:0]       src_data;
   logic [7:0]       line_byte;
   always_comb begin
      in_pre    = state == S_PRE;
      in_pay    = state == S_PAY;
      in_fcs    = state == S_FCS;
      sfd       = in_pre && pre_cnt == PW'(PREAMBLE_LEN);
      src_data  = gnt_udp ? bus.udp_data : bus.arp_data;
      src_done  = in_pay && (gnt_udp ? bus.udp_data_done : bus.arp_data_done);
      line_byte = in_pre ? (sfd ? 8'hD5 : 8'h55) : in_pay ? src_data : in_fcs ? bus.fcs_byte : 8'h00;
   end
   assign bus.arp_start            = sfd && !gnt_udp;
   assign bus.udp_start            = sfd && gnt_udp;
   assign bus.preamble_sfd_tx_done = sfd;
   assign bus.fcs_data             = in_pay ? src_data : 8'h00;
   assign bus.payload_done         = src_done;
   assign bus.busy                 = state != S_IDLE;
   assign bus.arp_frame_cnt        = arp_cnt;
   assign bus.udp_frame_cnt        = udp_cnt;
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state       <= S_IDLE;
         pre_cnt     <= '0;
         ifg_cnt     <= '0;
         gnt_udp     <= 1'b0;
         last_udp    <= 1'b1;
         arp_cnt     <= '0;
         udp_cnt     <= '0;
         bus.tx_data <= 8'h00;
         bus.tx_en   <= 1'b0;
      end else begin
         bus.tx_data <= line_byte;
         bus.tx_en   <= in_pre || in_pay || in_fcs;
         case (state)
            S_IDLE: if (bus.arp_req || bus.udp_req) begin
               // on a tie the source not served last wins
               gnt_udp <= bus.udp_req && (!bus.arp_req || !last_udp);
               pre_cnt <= '0;
               state   <= S_PRE;
            end
            S_PRE: begin
               pre_cnt <= pre_cnt + PW'(1);
               if (sfd) state <= S_PAY;
            end
            S_PAY: if (src_done) begin
               last_udp <= gnt_udp;
               state    <= S_FCS;
            end
            S_FCS: if (bus.fcs_tx_done) begin
               if (gnt_udp) udp_cnt <= udp_cnt + CNT_W'(1);
               else arp_cnt <= arp_cnt + CNT_W'(1);
               ifg_cnt <= IW'(IFG_CYCLES - 1);
               state   <= S_IFG;
            end
            S_IFG: begin
               ifg_cnt <= ifg_cnt - IW'(1);
               if (ifg_cnt == '0) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
